// File: rtl/simple_pkg.sv
// rtl/simple_pkg.sv - shared register-file widths and write-back entry type
package simple_pkg;
  localparam int REG_W      = 16;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_W-1:0]      data;
    logic                  rdy;
  } wb_entry_t;
endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - busy mask from queued destinations and RAW decode stall
module wb_scoreboard
  import simple_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]            valid,
  input  logic [DEPTH*REG_ADDR_W-1:0] rd_list,
  input  logic [PTR_W-1:0]            head,
  input  logic                        pop,
  input  logic [REG_ADDR_W-1:0]       rs,
  input  logic [REG_ADDR_W-1:0]       rd,
  input  logic                        rs_used,
  input  logic                        rd_used,
  output logic [NUM_REGS-1:0]         busy,
  output logic                        stall
);
  logic rd_used_busy;

  // The retiring head is bypassed by the register file, so it no longer counts as busy.
  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && !(pop && head == PTR_W'(i)))
        busy[rd_list[i*REG_ADDR_W +: REG_ADDR_W]] = 1'b1;
    end
  end

  assign rd_used_busy = busy[rd];
  assign stall = (rs_used & busy[rs]) | (rd_used & rd_used_busy);
endmodule

// File: rtl/writeback_buffer.sv
// rtl/writeback_buffer.sv - in-order write-back queue with in-order load fill
module writeback_buffer
  import simple_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic                  ex_wb_en,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_W-1:0]      ex_data,
  output logic                  ex_ready,
  input  logic                  mem_valid,
  input  logic [REG_W-1:0]      mem_data,
  input  logic                  wb_phase,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  rs_used,
  input  logic                  rd_used,
  output logic                  stall,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  regWrite,
  output logic [REG_ADDR_W-1:0] writeRegister,
  output logic [REG_W-1:0]      writeData,
  output logic                  changeEnable,
  output logic                  mem_err
);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  wb_entry_t                   entry_q [DEPTH];
  logic [DEPTH-1:0]            valid_q;
  logic [PTR_W-1:0]            head, tail, fill_idx, scan_idx;
  logic [PTR_W:0]              count;
  logic                        fill_found, enq, pop;
  logic [DEPTH*REG_ADDR_W-1:0] rd_list;

  assign ex_ready      = (count != FULL);
  assign enq           = ex_valid & ex_wb_en & ex_ready;
  assign regWrite      = (count != '0) & entry_q[head].rdy;
  assign writeRegister = entry_q[head].rd;
  assign writeData     = entry_q[head].data;
  assign changeEnable  = wb_phase;
  assign pop           = regWrite & wb_phase;

  // Fill target: oldest queued entry still waiting on memory, scanned from the head.
  always_comb begin
    fill_found = 1'b0;
    fill_idx   = '0;
    scan_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head + PTR_W'(i);
      if (!fill_found && ((PTR_W+1)'(i) < count) && !entry_q[scan_idx].rdy) begin
        fill_found = 1'b1;
        fill_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    rd_list = '0;
    for (int i = 0; i < DEPTH; i++)
      rd_list[i*REG_ADDR_W +: REG_ADDR_W] = entry_q[i].rd;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      valid_q <= '0;
      mem_err <= 1'b0;
    end else begin
      if (mem_valid) begin
        if (fill_found) begin
          entry_q[fill_idx].data <= mem_data;
          entry_q[fill_idx].rdy  <= 1'b1;
        end else begin
          mem_err <= 1'b1;
        end
      end
      if (pop) begin
        valid_q[head] <= 1'b0;
        head          <= head + PTR_W'(1);
      end
      if (enq) begin
        entry_q[tail] <= '{rd: ex_rd, data: ex_data, rdy: !ex_is_load};
        valid_q[tail] <= 1'b1;
        tail          <= tail + PTR_W'(1);
      end
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  wb_scoreboard #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_scoreboard (
    .valid   (valid_q),
    .rd_list (rd_list),
    .head    (head),
    .pop     (pop),
    .rs      (rs),
    .rd      (rd),
    .rs_used (rs_used),
    .rd_used (rd_used),
    .busy    (busy),
    .stall   (stall)
  );
endmodule

// File: tb/tb_writeback_buffer.sv
// tb/tb_writeback_buffer.sv - directed plus random checks against a queue model
module tb_writeback_buffer;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 0, ex_wb_en = 0, ex_is_load = 0;
  logic [2:0]  ex_rd = 0;
  logic [15:0] ex_data = 0;
  logic        ex_ready;
  logic        mem_valid = 0;
  logic [15:0] mem_data = 0;
  logic        wb_phase = 0;
  logic [2:0]  rs = 0, rd = 0;
  logic        rs_used = 0, rd_used = 0;
  logic        stall;
  logic [7:0]  busy;
  logic        regWrite;
  logic [2:0]  writeRegister;
  logic [15:0] writeData;
  logic        changeEnable;
  logic        mem_err;

  writeback_buffer #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_wb_en(ex_wb_en), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(ex_ready),
    .mem_valid(mem_valid), .mem_data(mem_data), .wb_phase(wb_phase),
    .rs(rs), .rd(rd), .rs_used(rs_used), .rd_used(rd_used),
    .stall(stall), .busy(busy), .regWrite(regWrite),
    .writeRegister(writeRegister), .writeData(writeData),
    .changeEnable(changeEnable), .mem_err(mem_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] data;
    bit          rdy;
  } ent_t;

  ent_t q[$];
  bit   m_err = 0;
  bit   checking = 0;
  int   fix_rs = -1;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit         e_rw, e_pop, e_stall;
    logic [7:0] e_busy;
    e_rw   = (q.size() > 0) && q[0].rdy;
    e_pop  = e_rw && wb_phase;
    e_busy = '0;
    foreach (q[i]) if (!(i == 0 && e_pop)) e_busy[q[i].rd] = 1'b1;
    e_stall = (rs_used && e_busy[rs]) || (rd_used && e_busy[rd]);
    chk("regWrite", 32'(regWrite), 32'(e_rw));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("stall", 32'(stall), 32'(e_stall));
    chk("ex_ready", 32'(ex_ready), 32'(q.size() < DEPTH));
    chk("mem_err", 32'(mem_err), 32'(m_err));
    chk("changeEnable", 32'(changeEnable), 32'(wb_phase));
    if (e_rw) begin
      chk("writeRegister", 32'(writeRegister), 32'(q[0].rd));
      chk("writeData", 32'(writeData), 32'(q[0].data));
    end
  endtask

  task automatic model_update();
    bit pop, enq, found;
    if (reset) begin
      q.delete();
      m_err = 0;
      return;
    end
    pop = (q.size() > 0) && q[0].rdy && wb_phase;
    enq = ex_valid && ex_wb_en && (q.size() < DEPTH);
    if (mem_valid) begin
      found = 0;
      foreach (q[i]) if (!found && !q[i].rdy) begin
        q[i].data = mem_data;
        q[i].rdy  = 1;
        found     = 1;
      end
      if (!found) m_err = 1;
    end
    if (pop) void'(q.pop_front());
    if (enq) q.push_back('{rd: ex_rd, data: ex_is_load ? 16'h0 : ex_data, rdy: !ex_is_load});
  endtask

  task automatic cyc(input bit v, input bit ld, input logic [2:0] r, input logic [15:0] d,
                     input bit mv, input logic [15:0] md, input bit wp, input bit rst = 0);
    reset = rst; ex_valid = v; ex_wb_en = v; ex_is_load = ld; ex_rd = r; ex_data = d;
    mem_valid = mv; mem_data = md; wb_phase = wp;
    if (fix_rs >= 0) begin
      rs = 3'(fix_rs); rs_used = 1; rd_used = 0; rd = 3'($urandom);
    end else begin
      rs = 3'($urandom); rd = 3'($urandom); rs_used = 1'($urandom); rd_used = 1'($urandom);
    end
    #1;
    if (checking) check_outputs();
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    checking = 1;
    cyc(0, 0, 0, 0, 0, 0, 0);

    // ALU write r3
    cyc(1, 0, 3, 16'h1234, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // Load r5 with a stalled reader on r5
    fix_rs = 5;
    cyc(1, 1, 5, 16'hFFFF, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 16'hBEEF, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    fix_rs = -1;

    // Ready ALU entry blocked behind an unfilled load
    cyc(1, 1, 1, 0, 0, 0, 1);
    cyc(1, 0, 2, 16'h0007, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 16'h5555, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // Fill to DEPTH, drop on full, then pop with enqueue and wrap
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 3'(i), 16'h1000 + 16'(i), 0, 0, 0);
    cyc(1, 0, 6, 16'hAAAA, 0, 0, 0);
    cyc(1, 0, 7, 16'hBBBB, 0, 0, 1);
    cyc(1, 0, 7, 16'h7777, 0, 0, 1);
    for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 0, 0, 0, 0, 1);

    // Orphan load data and same-cycle fill
    cyc(0, 0, 0, 0, 1, 16'hDEAD, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 4, 0, 1, 16'h4444, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // Reset with two loads outstanding
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 2, 0, 0, 0, 1);
    cyc(1, 1, 6, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 16'h9999, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      bit pend, mv;
      pend = 0;
      foreach (q[i]) if (!q[i].rdy) pend = 1;
      mv = pend ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 2);
      cyc($urandom_range(0, 1), $urandom_range(0, 99) < 40, 3'($urandom), 16'($urandom),
          mv, 16'($urandom), $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/writeback_buffer.md
Name: writeback_buffer

Overview:
- In-order write-back buffer that sits between the execute/memory stages and the 8x16-bit register file write port.
- Queues ALU results and outstanding loads, fills load data as memory returns it, and retires entries one per write-enabled cycle.
- Drives the register file signals regWrite, writeRegister, writeData and changeEnable.
- Exports a per-register busy scoreboard and a decode stall for read-after-write hazards.

Parameters:
- DEPTH, 4, number of buffer entries (power of 2, minimum 2).
- PTR_W, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high
- ex_valid  input  1  execute stage presents an instruction this cycle
- ex_wb_en  input  1  instruction writes a register
- ex_is_load  input  1  result will come from memory, not ex_data
- ex_rd  input  3  destination register
- ex_data  input  16  ALU result (ignored for loads)
- ex_ready  output  1  buffer can accept (count < DEPTH)
- mem_valid  input  1  load data returning this cycle
- mem_data  input  16  load data
- wb_phase  input  1  write-back phase strobe
- rs  input  3  decode source A
- rd  input  3  decode source B
- rs_used  input  1  source A is read
- rd_used  input  1  source B is read
- stall  output  1  decode must hold
- busy  output  8  bit i set if any entry targets register i
- regWrite  output  1  to register file
- writeRegister  output  3  to register file
- writeData  output  16  to register file
- changeEnable  output  1  to register file, equals wb_phase
- mem_err  output  1  sticky: mem_valid arrived with no pending load

Behaviour:
- Reset (synchronous, highest priority):
  - count=0, all entries invalid, load pointer at head, mem_err=0.
  - Resulting outputs: regWrite=0, busy=0, stall=0, ex_ready=1.
  - Reset mid-operation flushes all entries, including outstanding loads. Load data returned after reset sets mem_err.
- Entry fields: rd[2:0], data[15:0], rdy. The buffer is a circular FIFO with head and tail pointers plus a count.
- Enqueue: accepted when ex_valid & ex_wb_en & ex_ready.
  - ALU result: rdy=1, data=ex_data.
  - Load: rdy=0.
  - ex_valid with ex_wb_en=0 is ignored.
  - Enqueue while ex_ready=0 is a protocol violation: the entry is dropped and the count is unchanged.
- Load fill: a fill pointer tracks the oldest entry with rdy=0 (loads return in order).
  - On mem_valid, that entry gets data=mem_data and rdy=1, and the fill pointer advances past ALU entries to the next rdy=0 entry.
  - mem_valid with no rdy=0 entry sets mem_err; it is cleared only by reset.
  - If the entry is filled in the same cycle it is enqueued, the fill is ignored and mem_err is set (minimum load latency is 1 cycle).
- Retire: the outputs are combinational from the head entry.
  - regWrite = (count!=0) & head.rdy; writeRegister = head.rd; writeData = head.data; changeEnable = wb_phase.
  - The head pops at the clock edge when regWrite & wb_phase.
  - One retire per cycle at most. A head whose data is not ready blocks younger ready entries (strict order).
- Simultaneous events:
  - Enqueue plus pop in the same cycle: count unchanged. When full, ex_ready stays 0 that cycle because there is no pass-through.
  - Fill of the head plus pop in the same cycle cannot occur, because regWrite uses registered rdy. The head retires the next write phase.
- Scoreboard: busy[i] = OR over valid entries of (rd==i), excluding the head when regWrite & wb_phase. The register file bypasses that write combinationally.
- Stall: stall = (rs_used & busy[rs]) | (rd_used & rd_used_busy), where rd_used_busy is busy[rd]. stall is combinational.
- Wrap-around: pointers wrap modulo DEPTH. count runs 0..DEPTH.

Decomposition:
- Shared package (simple_pkg): REG_W=16, REG_ADDR_W=3, NUM_REGS=8, and the wb_entry_t typedef {rd, data, rdy}.
- One natural sub-module: wb_scoreboard, which decodes valid entries into the busy mask and computes stall. The FIFO and fill logic stay in the top level.

Test Plan:
- Reset, then ALU enqueue rd=3, data=16'h1234, with wb_phase=1 the next cycle -> regWrite=1, writeRegister=3, writeData=16'h1234; busy[3]=0 while writing; count returns to 0.
- Load rd=5 enqueued, mem_valid with 16'hBEEF three cycles later, wb_phase held 1 -> regWrite=0 and busy[5]=1 until the fill; write of 16'hBEEF one cycle after the fill. stall=1 with rs=5 & rs_used until the retire.
- Load rd=1, then ALU rd=2 (16'h0007) -> the ALU entry does not retire until the load fills; writes occur in order r1 then r2.
- Enqueue DEPTH ALU entries with wb_phase=0 -> ex_ready=0. Assert wb_phase with a simultaneous enqueue -> the head pops and ex_ready returns to 1 the next cycle. Pointers wrap and data order is preserved.
- mem_valid with an empty buffer -> mem_err=1 and remains 1 until reset.
- Two loads pending, reset asserted -> busy=0, regWrite=0, ex_ready=1. A later mem_valid sets mem_err and no register write occurs.
